ram_writer_bhl: RTL and testbench
=================================

RAM_WRITER_BHL -- requirements
Module: ram_writer_bhl

Interface
REQ-001 Parameter DATA_W, default 14, word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; depth = 2**ADDR_W = 8 words.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  one-cycle request to begin a full load of all 8 words.
REQ-006 Port bit_in  input  1  serial data bit, word MSB first.
REQ-007 Port bit_valid  input  1  bit_in qualifier; one bit accepted per cycle when high.
REQ-008 Port addr  input  ADDR_W  read address.
REQ-009 Port dout  output  DATA_W  read data, mem[addr].
REQ-010 Port busy  output  1  high while a load is in progress.
REQ-011 Port done  output  1  sticky, high after a complete 8-word load.
REQ-012 Port wr_addr  output  ADDR_W  address of the word currently being assembled.

Function
REQ-013 The block SHALL contain an 8 x DATA_W storage array, a DATA_W shift register, a bit counter 0..DATA_W-1 and a write pointer driving wr_addr.
REQ-014 The FSM SHALL have states IDLE, SHIFT, WRITE, DONE; busy = (state != IDLE).
REQ-015 IDLE: start=1 -> SHIFT next cycle; wr_addr <= 0, bit counter <= 0, done <= 0; bit_valid ignored in IDLE.
REQ-016 SHIFT: bit_valid=1 -> shift register <= {shift[DATA_W-2:0], bit_in}, bit counter +1; bit_valid=0 -> hold all state, no timeout.
REQ-017 SHIFT: acceptance of bit DATA_W-1 (14th bit) -> WRITE next cycle, bit counter <= 0.
REQ-018 WRITE (exactly one cycle): mem[wr_addr] <= shift register; wr_addr=7 -> DONE, else wr_addr +1 and -> SHIFT.
REQ-019 bit_valid during WRITE or DONE SHALL be ignored; the bit is dropped and not counted.
REQ-020 DONE (exactly one cycle): done <= 1, -> IDLE; done stays high until next accepted start or reset.
REQ-021 start while busy=1 SHALL be ignored with no effect on state, counters or memory.
REQ-022 dout SHALL be combinational mem[addr] at all times, including during a load.
REQ-023 Read of an address in its WRITE cycle SHALL return the old content; new content visible the cycle after.
REQ-024 Latency: 14th bit accepted in cycle N -> word stored at end of cycle N+1 -> visible on dout in cycle N+2.
REQ-025 Minimum full-load time: 1 + 8*(14+1) + 1 = 122 cycles from start to done high, with bit_valid continuously high except in WRITE.
REQ-026 wr_addr SHALL never wrap during a load; it returns to 0 only on start or reset.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state IDLE, busy=0, done=0, wr_addr=0, bit counter=0, shift register=0, all 8 memory words=0.
REQ-028 Reset mid-load SHALL abort the load with no partial word written; start is then required to reload.
REQ-029 Reset SHALL dominate start and bit_valid in the same cycle.

Verification
REQ-030 Reset, then read addr 0..7 -> dout=14'h0000 each; busy=0, done=0, wr_addr=0.
REQ-031 start, then 112 continuous valid bits of words 0x0001,0x3FFF,0x2AAA,0x1555,0x0000,0x2001,0x1234,0x3ABC (valid low in WRITE cycles) -> done high at cycle 122, addr k returns word k.
REQ-032 Load with bit_valid gaps (random low cycles) -> identical memory contents, busy high until DONE, done high once.
REQ-033 start pulsed during SHIFT of word 3 -> ignored, wr_addr stays 3, final contents unchanged vs. REQ-031.
REQ-034 rst_n low after 5 bits of word 2 -> busy=0, wr_addr=0, all words read 0; new start reloads correctly.
REQ-035 Hold addr=5 through WRITE of word 5 -> dout old value in WRITE cycle, new value next cycle; bit_valid=1 in WRITE cycle -> bit dropped, next word unaffected.

Source files
------------

// File: rtl/ram_writer_bhl.sv
// Serial-to-parallel RAM loader: assembles MSB-first bit streams into words and
// fills an 2**ADDR_W-deep register array, with a combinational read port.
module ram_writer_bhl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_addr
);

    // state | meaning
    // IDLE  | waiting for start
    // SHIFT | accepting serial bits of the current word
    // WRITE | one cycle, stores the assembled word at wr_addr
    // DONE  | one cycle, raises the sticky done flag
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        done_d  = done_q;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    shift_d = {shift_q[DATA_W-2:0], bit_in};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                we = 1'b1;
                // Pointer saturates on the last word so wr_addr never wraps mid-load.
                if (ptr_q == PTR_LAST) begin
                    state_d = DONE;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = SHIFT;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            if (we) begin
                mem_q[ptr_q] <= shift_q;
            end
        end
    end

    assign dout    = mem_q[addr];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign wr_addr = ptr_q;

endmodule

// File: tb/tb_ram_writer_bhl.sv
// Scoreboard bench for ram_writer_bhl: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ram_writer_bhl;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wr_addr;

    ram_writer_bhl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .addr(addr), .dout(dout), .busy(busy),
        .done(done), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    // kind: 0 dout, 1 busy, 2 done, 3 wr_addr, 4 done rises since last kind-4 check
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t       sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rises = 0;
    logic        prev_done = 1'b0;
    logic [DATA_W-1:0] words [8];
    logic [DATA_W-1:0] zero_w = '0;

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        if (done === 1'b1 && prev_done !== 1'b1) rises++;
        prev_done = done;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.kind)
                0:       act = 32'(dout);
                1:       act = 32'(busy);
                2:       act = 32'(done);
                3:       act = 32'(wr_addr);
                default: act = 32'(rises);
            endcase
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: actual %0h required %0h (t=%0t)", it.name, act, it.exp, $time);
            end
            if (it.kind == 4) rises = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: busy still high after %0d cycles (t=%0t)", name, max_cycles, $time);
        end
    endtask

    task automatic read_all(input bit expect_zero, input string name);
        for (int a = 0; a < 8; a++) begin
            addr = ADDR_W'(a);
            push(0, expect_zero ? 32'(zero_w) : 32'(words[a]), $sformatf("%s[%0d]", name, a));
            tick();
        end
    endtask

    task automatic shift_bits(input logic [DATA_W-1:0] w, input int nbits);
        for (int b = DATA_W - 1; b >= DATA_W - nbits; b--) begin
            bit_valid = 1'b1;
            bit_in    = w[b];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // Full load; word 5 WRITE cycle carries a stray valid bit and is watched on addr 5.
    task automatic do_load(input bit gaps, input bit glitch);
        start = 1'b1;
        tick();
        start = 1'b0;
        push(1, 1, "busy_after_start");
        push(2, 0, "done_cleared_on_start");
        for (int w = 0; w < 8; w++) begin
            for (int b = DATA_W - 1; b >= 0; b--) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'b1;
                    tick();
                    if (w == 4 && b == 7) push(1, 1, "busy_in_gap");
                end
                bit_valid = 1'b1;
                bit_in    = words[w][b];
                if (glitch && w == 3 && b == 6) start = 1'b1;
                tick();
                start = 1'b0;
                if (glitch && w == 3 && b == 6) push(3, 3, "wr_addr_after_start_glitch");
            end
            push(3, 32'(w), $sformatf("wr_addr_write%0d", w));
            if (w == 5) begin
                addr = 3'd5;
                push(0, 32'(zero_w), "dout_old_in_write5");
                bit_valid = 1'b1;
                bit_in    = 1'b1;
            end else begin
                bit_valid = 1'b0;
            end
            tick();
            if (w == 5) push(0, 32'(words[5]), "dout_new_after_write5");
        end
        push(1, 1, "busy_in_done_state");
        push(2, 0, "done_low_in_done_state");
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_valid = 1'b0;
        push(2, 1, "done_high");
        push(1, 0, "busy_low_after_done");
        push(3, 7, "wr_addr_no_wrap");
        push(4, 1, "done_rises_once");
    endtask

    initial begin
        words[0] = 14'h0001; words[1] = 14'h3FFF; words[2] = 14'h2AAA; words[3] = 14'h1555;
        words[4] = 14'h0000; words[5] = 14'h2001; words[6] = 14'h1234; words[7] = 14'h3ABC;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_now(32'(busy), 0, "reset_busy_now");
        check_now(32'(done), 0, "reset_done_now");
        check_now(32'(wr_addr), 0, "reset_wr_addr_now");
        push(1, 0, "reset_busy");
        push(2, 0, "reset_done");
        push(3, 0, "reset_wr_addr");
        read_all(1'b1, "reset_mem");

        // continuous load; done must rise exactly 121 edges after the start edge
        do_load(1'b0, 1'b0);
        read_all(1'b0, "load1_mem");

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        do_load(1'b1, 1'b1);
        read_all(1'b0, "load2_mem");

        // abort mid-word-2, with start and bit_valid asserted alongside reset
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(words[0], DATA_W);
        tick();
        shift_bits(words[1], DATA_W);
        tick();
        shift_bits(words[2], 5);
        push(3, 2, "wr_addr_before_abort");
        rst_n     = 1'b0;
        start     = 1'b1;
        bit_valid = 1'b1;
        tick();
        rst_n     = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        check_now(32'(busy), 0, "abort_busy_now");
        check_now(32'(wr_addr), 0, "abort_wr_addr_now");
        push(1, 0, "abort_busy");
        push(2, 0, "abort_done");
        push(3, 0, "abort_wr_addr");
        read_all(1'b1, "abort_mem");
        push(1, 0, "abort_stays_idle");

        do_load(1'b0, 1'b0);
        wait_idle(10, "reload_idle_wait");
        read_all(1'b0, "reload_mem");

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drained: %0d items left (t=%0t)", sb_q.size(), $time);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
